// File: rtl/axis_block_averager.sv
// Decimating boxcar averager: sums non-overlapping blocks of 2^L signed AXIS
// samples and emits one arithmetically right-shifted mean per block.
module axis_block_averager #(
  parameter int AXIS_TDATA_WIDTH = 14,
  parameter int LOG2_MAX         = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [7:0]                  cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int ACC_W = AXIS_TDATA_WIDTH + LOG2_MAX;
  localparam int CNT_W = LOG2_MAX + 1;

  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [4:0]                    l_q, l_d;
  logic [AXIS_TDATA_WIDTH-1:0]   data_q, data_d;
  logic                          valid_q, valid_d;

  logic [4:0]                    cfg_l;
  logic [4:0]                    l_eff;
  logic [CNT_W-1:0]              last_cnt;
  logic                          accept;
  logic                          block_end;
  logic signed [ACC_W-1:0]       sample_ext;
  logic signed [ACC_W-1:0]       sum;
  logic signed [ACC_W-1:0]       mean;

  // Ready depends only on the output register, so the completing sample of a
  // block always finds the register free or being drained on the same edge.
  assign s_axis_tready = ~valid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;

  always_comb begin
    cfg_l      = (cfg_data[4:0] > 5'(LOG2_MAX)) ? 5'(LOG2_MAX) : cfg_data[4:0];
    // The first sample of a block uses the live config; later ones the latched L.
    l_eff      = (cnt_q == '0) ? cfg_l : l_q;
    last_cnt   = (CNT_W'(1) << l_eff) - CNT_W'(1);
    block_end  = accept && (cnt_q == last_cnt);
    sample_ext = {{LOG2_MAX{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
    sum        = acc_q + sample_ext;
    mean       = sum >>> l_eff;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (valid_q && m_axis_tready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (cnt_q == '0) begin
        l_d = cfg_l;
      end
      if (block_end) begin
        data_d  = mean[AXIS_TDATA_WIDTH-1:0];
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_axis_block_averager.sv
// Self-checking bench for axis_block_averager: directed and random stimulus
// against a queue-based block-mean model with floor-division arithmetic.
module tb_axis_block_averager;

  localparam int W = 14;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [7:0]          cfg_data;
  logic signed [W-1:0] s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic signed [W-1:0] m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;

  axis_block_averager #(
    .AXIS_TDATA_WIDTH(W),
    .LOG2_MAX        (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfg_data),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int cyc;
  } exp_t;
  exp_t expq[$];

  int     mcnt = 0;
  int     ml = 0;
  longint msum = 0;
  int     n_out = 0;
  int     last_out = 0;
  bit     rand_ready = 1'b0;
  bit     prev_valid = 1'b0;
  bit     prev_cons = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mean of a block rounded toward minus infinity.
  function automatic int floor_mean(input longint s, input int l);
    longint d;
    longint q;
    d = longint'(1) << l;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_accept(input int d);
    exp_t e;
    if (mcnt == 0) begin
      ml = int'(cfg_data[4:0]);
      if (ml > 16) ml = 16;
      msum = 0;
    end
    msum += d;
    mcnt++;
    if (mcnt == (1 << ml)) begin
      e.data = floor_mean(msum, ml);
      e.cyc  = cyc + 1;
      expq.push_back(e);
      mcnt = 0;
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    msum = 0;
    expq.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d);
    int unsigned guard;
    guard = 0;
    s_axis_tdata  = d[W-1:0];
    s_axis_tvalid = 1'b1;
    if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    #2;
    while (!s_axis_tready && guard < 1000) begin
      @(negedge aclk);
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
      #2;
      guard++;
    end
    if (!s_axis_tready) chk("send_timeout", {31'd0, s_axis_tready}, 1);
    else model_accept(d);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    while ((expq.size() != 0 || m_axis_tvalid) && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    chk("drain_empty", expq.size(), 0);
    @(negedge aclk);
  endtask

  // Output monitor: checks every valid cycle's data against the queue head,
  // and the appearance cycle of each new word.
  always @(negedge aclk) begin
    #3;
    if (!aresetn) begin
      prev_valid = 1'b0;
      prev_cons  = 1'b0;
    end else begin
      if (m_axis_tvalid) begin
        if (expq.size() == 0) begin
          chk("spurious_word", {31'd0, m_axis_tvalid}, 0);
        end else begin
          if (!prev_valid || prev_cons) chk("word_latency", cyc, expq[0].cyc);
          chk("word_data", m_axis_tdata, expq[0].data);
          if (m_axis_tready) begin
            void'(expq.pop_front());
            n_out++;
            last_out = int'(m_axis_tdata);
          end
        end
      end
      prev_valid = m_axis_tvalid;
      prev_cons  = m_axis_tvalid && m_axis_tready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", ncmp, nfail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int v;
    aresetn       = 1'b0;
    cfg_data      = 8'd0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    repeat (2) @(negedge aclk);
    #2;
    chk("reset_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    #2;
    chk("ready_after_reset", {31'd0, s_axis_tready}, 1);
    @(negedge aclk);

    // L=0 pass-through, back-to-back including both full-scale extremes
    cfg_data = 8'd0;
    base = n_out;
    send(5); send(-3); send(8191); send(-8192);
    drain();
    chk("l0_count", n_out - base, 4);
    chk("l0_last", last_out, -8192);

    // L=2 averaging and floor rounding
    cfg_data = 8'd2;
    send(1); send(2); send(3); send(6);
    drain();
    chk("l2_mean", last_out, 3);
    send(-1); send(-1); send(-1); send(-2);
    drain();
    chk("l2_floor", last_out, -2);

    // Full scale at L=16 (cfg 17 with upper bits set clamps to 16)
    cfg_data = 8'hF1;
    base = n_out;
    repeat (65536) send(-8192);
    drain();
    chk("l16_count", n_out - base, 1);
    chk("l16_neg_full", last_out, -8192);
    cfg_data = 8'd12;
    base = n_out;
    repeat (4096) send(8191);
    drain();
    chk("l12_count", n_out - base, 1);
    chk("l12_pos_full", last_out, 8191);

    // Backpressure at L=1: word held, input refused
    cfg_data = 8'd1;
    base = n_out;
    send(100); send(-50);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 14'sd77;
    repeat (4) begin
      #2;
      chk("bp_sready", {31'd0, s_axis_tready}, 0);
      chk("bp_mvalid", {31'd0, m_axis_tvalid}, 1);
      chk("bp_hold", m_axis_tdata, 25);
      @(negedge aclk);
    end
    m_axis_tready = 1'b1;
    send(77); send(-78); send(1); send(2);
    drain();
    chk("bp_count", n_out - base, 3);

    // Config change mid-block takes effect at the next block
    cfg_data = 8'd2;
    base = n_out;
    repeat (2) begin v = int'($urandom_range(0, 16383)) - 8192; send(v); end
    cfg_data = 8'd1;
    repeat (4) begin v = int'($urandom_range(0, 16383)) - 8192; send(v); end
    drain();
    chk("cfg_change_count", n_out - base, 2);

    // Asynchronous reset mid-block
    cfg_data = 8'd0;
    send(123);
    drain();
    cfg_data = 8'd3;
    repeat (5) send(100);
    #1;
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    base = n_out;
    repeat (8) send(10);
    drain();
    chk("post_rst_count", n_out - base, 1);
    chk("post_rst_mean", last_out, 10);

    // Random samples, config and downstream stalls
    rand_ready = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 49) == 0)
        cfg_data = 8'($urandom_range(0, 3)) | 8'($urandom_range(0, 7) << 5);
      if ($urandom_range(0, 7) == 0)
        v = ($urandom_range(0, 1) != 0) ? 8191 : -8192;
      else
        v = int'($urandom_range(0, 16383)) - 8192;
      send(v);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    cfg_data = 8'd0;
    send(0);
    drain();

    chk("final_queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/axis_block_averager.md
# axis_block_averager

Decimating boxcar averager for the signed sample stream leaving the offset/gain scaler. It accepts signed AXIS samples, sums non-overlapping blocks of 2^L samples and emits one arithmetically right-shifted mean per block. The output is registered, with full AXI-Stream backpressure. It sits between the scaler and the DMA/FIFO writer and reduces the data rate for slow acquisitions.

## Interface
- AXIS_TDATA_WIDTH, 14: sample width, signed two's complement, input and output.
- LOG2_MAX, 16: largest supported decimation exponent. Accumulator width is AXIS_TDATA_WIDTH+LOG2_MAX.

- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low, released synchronously to aclk.
- cfg_data  in  8  bits [4:0] are L, the decimation exponent; bits [7:5] are ignored. L > LOG2_MAX is clamped to LOG2_MAX.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  signed input sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block can accept a sample.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  signed block mean.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accepts.

## Operation
- Reset, while aresetn=0:
  - m_axis_tvalid=0, m_axis_tdata=0.
  - Accumulator=0, sample counter=0, latched exponent=0.
  - s_axis_tready=1 immediately after release.
- A sample is accepted when s_axis_tvalid & s_axis_tready.
- States:
  - IDLE: counter=0.
  - ACC: 0 < counter < 2^L.
  - Output holding: a word is pending and not yet taken.
- Configuration latching:
  - The clamped L is latched on the first accepted sample of each block (counter=0).
  - cfg_data changes mid-block have no effect until the next block starts.
- Accumulation: each accepted sample is sign-extended to AXIS_TDATA_WIDTH+LOG2_MAX bits and added to the accumulator. The counter increments.
- Block end: the accepted sample with counter = 2^L−1 completes the block.
  - Output register loads (acc + sample) >>> L_latched. The shift is arithmetic (floor toward −inf) and the result is truncated to the low AXIS_TDATA_WIDTH bits. This cannot overflow because the mean of in-range samples is in range.
  - Accumulator and counter clear to 0 on the same edge.
  - m_axis_tvalid=1 on the next cycle.
- L=0 is a pass-through: every accepted sample becomes an output word, with one cycle of registered latency.
- Output handshake:
  - m_axis_tvalid stays high and m_axis_tdata holds stable until m_axis_tready=1.
  - The word is consumed on the edge with tvalid & tready.
- Backpressure: s_axis_tready = ~m_axis_tvalid | m_axis_tready.
  - This is combinational from m_axis_tready only; there is no path from s_axis_tvalid to s_axis_tready.
  - Mid-block samples are accepted under the same rule. This is conservative, and it guarantees the completing sample never finds the output register occupied.
- Simultaneous events: if the output word is consumed and a new block completes on the same edge, the new word loads and m_axis_tvalid stays 1. Throughput is one word per cycle at L=0.
- No samples are ever dropped or duplicated. A partial block is discarded only by reset.

## Timing
- Latency is 1 cycle from acceptance of a block's last sample to m_axis_tvalid=1 with valid data.
- Sustained throughput:
  - 1 input sample per cycle while downstream is ready.
  - 1 output word per 2^L accepted samples.
- Asserting aresetn mid-block immediately:
  - discards the partial sum and counter;
  - drops any pending output word (m_axis_tvalid→0 asynchronously).
  The first block after release starts at counter=0.
- cfg_data is assumed quasi-static, but it is only sampled at block start, so it needs no synchronization beyond aclk.
- Counter wrap: the counter is LOG2_MAX+1 bits wide and is compared against 2^L−1. It never wraps past 2^LOG2_MAX−1.

## Test plan
- L=0 pass-through:
  - Stimulus: inputs 5, −3, 8191, −8192 back-to-back, m_axis_tready=1.
  - Required: outputs 5, −3, 8191, −8192, each 1 cycle after its input, no gaps.
- L=2 averaging:
  - Stimulus: inputs 1, 2, 3, 6.
  - Required: output 3. Then inputs −1, −1, −1, −2 (sum −5) give output −2, confirming floor rounding.
- Full-scale L=16:
  - Stimulus: 65536 samples of −8192.
  - Required: exactly one output, −8192, with no accumulator overflow. The same test with 8191 gives 8191.
- Backpressure:
  - Stimulus: L=1 with m_axis_tready held 0 after the first word is produced.
  - Required: the word is held stable and s_axis_tready=0, and no input is accepted. After m_axis_tready=1, the next pair completes and the word stream continues with no loss. Concurrent consume and load keeps m_axis_tvalid=1.
- Config change mid-block:
  - Stimulus: start L=2, feed 2 samples, change cfg to L=1, feed 2 more.
  - Required: one output, equal to the mean of all 4 samples. The next block uses L=1.
- Reset mid-block:
  - Stimulus: L=3, feed 5 samples of 100, pulse aresetn low asynchronously, release, feed 8 samples of 10.
  - Required: outputs go to 0 during reset, and the only output afterwards is 10.
